product_accumulator: RTL and testbench

//   Downstream stage of the signed 32x32->64 multiplier. Consumes a stream of

---
 rtl/product_accumulator_if.sv | 29 ++
 rtl/product_accumulator.sv | 104 ++++++++++
 tb/tb_product_accumulator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier wrapper, the product accumulator and
// its result consumer: run control, product stream in, result out.
interface product_accumulator_if #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed products into a saturating accumulator
// and returns sum, beat count and sticky saturation over a valid/ready port.
module product_accumulator #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_inc, len_q;
    logic             sat, sat_next;
    logic [ACC_W:0]   sum_wide;
    logic             ovf, beat, last;

    // One guard bit above the accumulator: overflow shows as top two bits differing.
    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign acc_next = ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    assign sat_next = sat | ovf;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign beat     = bus.in_valid && (state == ACCUM);
    assign last     = beat && (cnt_inc == len_q);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_next    = state;
        bus.busy      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = (bus.len == '0) ? HOLD : ACCUM;
            end
            ACCUM: begin
                bus.busy     = 1'b1;
                bus.in_ready = 1'b1;
                if (last) state_next = HOLD;
            end
            HOLD: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the datapath and result registers are reset as well, so a run
    // aborted by reset leaves zeros on out_sum/out_count instead of stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc           <= '0;
            cnt           <= '0;
            len_q         <= '0;
            sat           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            len_q <= bus.len;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            if (bus.len == '0) begin
                bus.out_sum   <= '0;
                bus.out_count <= '0;
                bus.out_sat   <= 1'b0;
            end
        end else if (beat) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            sat <= sat_next;
            if (last) begin
                bus.out_sum   <= acc_next;
                bus.out_count <= cnt_inc;
                bus.out_sat   <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (ACC_W=66 so saturation is reachable):
// table of runs fed through a result scoreboard, plus reset corner sequences.
module tb_product_accumulator;

    localparam int IN_W  = 64;
    localparam int ACC_W = 66;
    localparam int CNT_W = 16;

    localparam logic [63:0]      P    = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]      N    = 64'h8000_0000_0000_0000;
    localparam logic [63:0]      M1   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef struct packed {
        logic [CNT_W-1:0]     len;
        logic [5:0][IN_W-1:0] data;
        logic [7:0]           vpat;
        logic [7:0]           hold;
        logic                 start_in_hold;
        logic [ACC_W-1:0]     sum;
        logic [CNT_W-1:0]     count;
        logic                 sat;
    } vec_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;
    exp_t exp_q[$];
    vec_t vecs[9];

    product_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    product_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t make_vec(
        input logic [CNT_W-1:0] len,
        input logic [IN_W-1:0] d0, d1, d2, d3, d4, d5,
        input logic [7:0] vpat, input logic [7:0] hold, input logic sih,
        input logic [ACC_W-1:0] sum, input logic [CNT_W-1:0] count, input logic sat);
        vec_t v;
        v.len           = len;
        v.data          = {d5, d4, d3, d2, d1, d0};
        v.vpat          = vpat;
        v.hold          = hold;
        v.start_in_hold = sih;
        v.sum           = sum;
        v.count         = count;
        v.sat           = sat;
        return v;
    endfunction

    // Drives one complete run; the expected result is queued at start and
    // popped when the DUT's result handshake occurs.
    task automatic run_vec(input vec_t v);
        int   k = 0;
        int   c = 0;
        logic beat;
        logic [ACC_W-1:0] held;
        exp_t e;
        exp_q.push_back('{sum: v.sum, count: v.count, sat: v.sat});
        bus.start = 1'b1;
        bus.len   = v.len;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = '0;
        check("busy_after_start", bus.busy, 1);
        check("in_ready_after_start", bus.in_ready, (v.len != 0) ? 1 : 0);
        while (k < int'(v.len) && c < 200) begin
            bus.in_valid = (c < 8) ? v.vpat[c] : 1'b1;
            bus.in_data  = v.data[(k < 6) ? k : 5];
            beat = bus.in_valid & bus.in_ready;
            @(negedge clk);
            if (beat) k++;
            c++;
        end
        bus.in_valid = 1'b0;
        check("beats_done", k, v.len);
        check("out_valid_latency", bus.out_valid, 1);
        check("in_ready_low_in_hold", bus.in_ready, 0);
        held = bus.out_sum;
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.out_ready = 1'b0;
            bus.start     = v.start_in_hold;
            bus.len       = 16'd2;
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_sum_stable", bus.out_sum, held);
        end
        bus.start     = 1'b1;
        bus.len       = 16'd3;
        bus.out_ready = 1'b1;
        check("handshake_valid", bus.out_valid, 1);
        check("scoreboard_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (bus.out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_sum", bus.out_sum, e.sum);
            check("out_count", bus.out_count, e.count);
            check("out_sat", bus.out_sat, e.sat);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 0);
        check("idle_after_handshake", bus.busy, 0);
    endtask

    initial begin
        logic seen_valid;

        vecs[0] = make_vec(16'd3, 64'd5, -64'sd2, 64'd10, 0, 0, 0, 8'hFF, 8'd0, 1'b0,
                           66'd13, 16'd3, 1'b0);
        vecs[1] = make_vec(16'd4, 64'd1, 64'd2, 64'd3, 64'd4, 0, 0, 8'b0010_1101, 8'd5, 1'b1,
                           66'd10, 16'd4, 1'b0);
        vecs[2] = make_vec(16'd0, 0, 0, 0, 0, 0, 0, 8'hFF, 8'd1, 1'b1,
                           66'd0, 16'd0, 1'b0);
        vecs[3] = make_vec(16'd5, P, P, P, P, P, P, 8'hFF, 8'd0, 1'b0,
                           SMAX, 16'd5, 1'b1);
        vecs[4] = make_vec(16'd5, N, N, N, N, N, N, 8'hFF, 8'd0, 1'b0,
                           SMIN, 16'd5, 1'b1);
        vecs[5] = make_vec(16'd4, N, N, N, N, 0, 0, 8'hFF, 8'd0, 1'b0,
                           SMIN, 16'd4, 1'b0);
        vecs[6] = make_vec(16'd6, P, P, P, P, P, M1, 8'hFF, 8'd0, 1'b0,
                           SMAX - 66'd1, 16'd6, 1'b1);
        vecs[7] = make_vec(16'd3, 64'd5, -64'sd2, 64'd10, 0, 0, 0, 8'hFF, 8'd0, 1'b0,
                           66'd13, 16'd3, 1'b0);
        vecs[8] = make_vec(16'd2, -64'sd7, -64'sd8, 0, 0, 0, 0, 8'b0000_0101, 8'd2, 1'b0,
                           -66'sd15, 16'd2, 1'b0);

        // Reset held while inputs are active.
        bus.start     = 1'b1;
        bus.len       = 16'd3;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'd5;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_sat", bus.out_sat, 0);
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a run discards it without a result.
        bus.start = 1'b1;
        bus.len   = 16'd5;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'd100;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_sum", bus.out_sum, 0);
        check("midrst_out_count", bus.out_count, 0);
        @(negedge clk);
        rst = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_valid |= bus.out_valid | bus.in_ready;
        end
        bus.in_valid = 1'b0;
        check("midrst_no_output", seen_valid, 0);
        check("midrst_idle", bus.busy, 0);

        run_vec(make_vec(16'd1, 64'd7, 0, 0, 0, 0, 0, 8'hFF, 8'd0, 1'b0,
                         66'd7, 16'd1, 1'b0));

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
